msu_sd_sector_responder: RTL and testbench

//   Responder (host) side of the sd_rd/sd_lba/sd_ack/sd_buff_wr sector-read protocol used by the MSU audio fetcher.

---
 rtl/msu_sd_sector_responder.sv | 163 ++++++++++++++++
 tb/tb_msu_sd_sector_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_sd_sector_responder.sv
// Host-side responder for the sd_rd/sd_ack/sd_buff_wr sector-read protocol.
// Fetches a sector word by word from backing memory; bytes at or past img_size read as zero.
module msu_sd_sector_responder #(
  parameter int unsigned LBA_W     = 21,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ACK_DELAY = 3,
  parameter int unsigned MEM_AW    = 29
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       img_size,
  input  logic              sd_rd,
  input  logic [LBA_W-1:0]  sd_lba,
  output logic              sd_ack,
  output logic [ADDR_W-1:0] sd_buff_addr,
  output logic [DATA_W-1:0] sd_buff_dout,
  output logic              sd_buff_wr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err_range
);

  typedef enum logic [2:0] {StIdle, StAckDly, StFetch, StWaitD, StWrite, StDone} state_e;

  localparam logic [DATA_W-1:0] LowByte = DATA_W'(8'hFF);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [LBA_W-1:0]    lba_q, lba_d;
  logic [31:0]         img_q, img_d;
  logic [ADDR_W-1:0]   w_q, w_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic                ack_q, ack_d;
  logic                wr_q, wr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // 64-bit arithmetic so offsets past 2**32 compare as out of range instead of wrapping
  logic [63:0] off_w;
  logic        off_oor;
  logic        off_tail;

  always_comb begin
    off_w    = (64'(lba_q) << 9) + (64'(w_q) << 1);
    off_oor  = off_w >= 64'(img_q);
    off_tail = (off_w + 64'd1) == 64'(img_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lba_d      = lba_q;
    img_d      = img_q;
    w_d        = w_q;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    wr_d       = 1'b0;
    mem_rd_d   = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (sd_rd) begin
          lba_d   = sd_lba;
          img_d   = img_size;
          busy_d  = 1'b1;
          cnt_d   = 4'(ACK_DELAY);
          err_d   = (64'(sd_lba) << 9) >= 64'(img_size);
          state_d = StAckDly;
        end
      end
      StAckDly: begin
        cnt_d = cnt_q - 4'd1;
        // Ack rises as the counter expires, giving ACK_DELAY cycles without ack after accept
        if (cnt_q <= 4'd1) begin
          ack_d   = 1'b1;
          w_d     = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (off_oor) begin
          data_d  = '0;
          wr_d    = 1'b1;
          state_d = StWrite;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = MEM_AW'({lba_q, w_q});
          state_d    = StWaitD;
        end
      end
      StWaitD: begin
        if (mem_valid) begin
          data_d  = off_tail ? (mem_rdata & LowByte) : mem_rdata;
          wr_d    = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (&w_q) begin
          state_d = StDone;
        end else begin
          w_d     = w_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lba_q      <= '0;
      img_q      <= '0;
      w_q        <= '0;
      data_q     <= '0;
      mem_addr_q <= '0;
      ack_q      <= 1'b0;
      wr_q       <= 1'b0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lba_q      <= lba_d;
      img_q      <= img_d;
      w_q        <= w_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      ack_q      <= ack_d;
      wr_q       <= wr_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign sd_ack       = ack_q;
  assign sd_buff_addr = w_q;
  assign sd_buff_dout = data_q;
  assign sd_buff_wr   = wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign busy         = busy_q;
  assign err_range    = err_q;

endmodule

// File: tb/tb_msu_sd_sector_responder.sv
// Scoreboard bench for msu_sd_sector_responder: stimulus pushes expected strobes,
// a negedge monitor pops and compares each sd_buff_wr strobe.
module tb_msu_sd_sector_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] img_size;
  logic        sd_rd;
  logic [20:0] sd_lba;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [28:0] mem_addr;
  logic        mem_rd;
  logic        mem_valid;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        err_range;

  always #5 clk = ~clk;

  msu_sd_sector_responder dut (
    .clk          (clk),
    .reset        (reset),
    .img_size     (img_size),
    .sd_rd        (sd_rd),
    .sd_lba       (sd_lba),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_valid    (mem_valid),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .err_range    (err_range)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t        sb_q[$];
  int          passed = 0;
  int          total = 0;
  int          strobes = 0;
  int          memrds = 0;
  int          errs = 0;
  logic        prev_wr = 1'b0;
  logic [15:0] seen [256];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // Backing memory: word at address a holds a[15:0], read latency 2 cycles
  logic        pend;
  logic [28:0] pend_addr;
  always @(negedge clk) begin
    if (reset) begin
      pend      = 1'b0;
      mem_valid = 1'b0;
    end else begin
      mem_valid = pend;
      mem_rdata = pend_addr[15:0];
      pend      = mem_rd;
      pend_addr = mem_addr;
      if (mem_rd) memrds++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (err_range) errs++;
      if (sd_buff_wr) begin
        strobes++;
        chk("wr_with_ack", 64'(sd_ack), 64'd1);
        chk("no_back_to_back", 64'(prev_wr), 64'd0);
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("strobe_addr", 64'(sd_buff_addr), 64'(e.a));
          chk("strobe_data", 64'(sd_buff_dout), 64'(e.d));
        end
        seen[sd_buff_addr] = sd_buff_dout;
      end
      prev_wr = sd_buff_wr;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic push_xfer(input logic [20:0] lba, input logic [31:0] img);
    for (int w = 0; w < 256; w++) begin
      logic [63:0] off;
      exp_t        e;
      off = 64'(lba) * 64'd512 + 64'(w) * 64'd2;
      e.a = 8'(w);
      if (off >= 64'(img)) begin
        e.d = 16'h0;
      end else begin
        e.d = 16'(64'(lba) * 64'd256 + 64'(w));
        if (off + 64'd1 == 64'(img)) e.d[15:8] = 8'h00;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_ack(input logic val, input int bound, input string name);
    int n = 0;
    while (sd_ack !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sd_ack), 64'(val));
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 256; i++) seen[i] = 16'hDEAD;
  endtask

  task automatic xfer(input logic [20:0] lba, input logic [31:0] img, input int exp_err,
                      input int exp_memrd);
    int s0 = strobes;
    int m0 = memrds;
    int e0 = errs;
    int lat = 0;
    clear_seen();
    push_xfer(lba, img);
    @(negedge clk);
    sd_lba   = lba;
    img_size = img;
    sd_rd    = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", 64'(busy), 64'd1);
    while (!sd_ack && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    chk("ack_latency", 64'(lat), 64'd3);
    sd_rd = 1'b0;
    wait_ack(1'b0, 3000, "ack_fall");
    chk("busy_low_after", 64'(busy), 64'd0);
    chk("strobe_count", 64'(strobes - s0), 64'd256);
    chk("mem_rd_count", 64'(memrds - m0), 64'(exp_memrd));
    chk("err_count", 64'(errs - e0), 64'(exp_err));
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int s0;
    int m0;
    int n;
    reset     = 1'b1;
    sd_rd     = 1'b0;
    sd_lba    = '0;
    img_size  = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(sd_ack), 64'd0);
    chk("rst_wr", 64'(sd_buff_wr), 64'd0);
    chk("rst_addr", 64'(sd_buff_addr), 64'd0);
    chk("rst_dout", 64'(sd_buff_dout), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_range), 64'd0);
    reset = 1'b0;

    // 1: full in-range sector, data = word address
    xfer(21'd0, 32'd1024, 0, 256);
    chk("s1_w0", 64'(seen[0]), 64'h0000);
    chk("s1_w255", 64'(seen[255]), 64'h00FF);

    // 2: only the first 4 bytes of sector 2 are in the image
    xfer(21'd2, 32'd1028, 0, 2);
    chk("s2_w0", 64'(seen[0]), 64'h0200);
    chk("s2_w1", 64'(seen[1]), 64'h0201);
    chk("s2_w2", 64'(seen[2]), 64'h0000);
    chk("s2_w255", 64'(seen[255]), 64'h0000);

    // 3: odd tail, high byte of word 1 masked
    xfer(21'd2, 32'd1027, 0, 2);
    chk("s3_w0", 64'(seen[0]), 64'h0200);
    chk("s3_w1", 64'(seen[1]), 64'h0001);

    // 4: sector beyond image, and an empty image
    xfer(21'd5, 32'd1024, 1, 0);
    chk("s4_w7", 64'(seen[7]), 64'h0000);
    xfer(21'd0, 32'd0, 1, 0);

    // 5: reset mid-transfer
    push_xfer(21'd0, 32'd1024);
    @(negedge clk);
    s0       = strobes;
    sd_lba   = 21'd0;
    img_size = 32'd1024;
    sd_rd    = 1'b1;
    wait_ack(1'b1, 50, "s5_ack_rise");
    sd_rd = 1'b0;
    n = 0;
    while (strobes < s0 + 100 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("s5_reached_100", 64'(strobes - s0), 64'd100);
    #2 reset = 1'b1;
    #1;
    chk("s5_ack", 64'(sd_ack), 64'd0);
    chk("s5_wr", 64'(sd_buff_wr), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_mem_rd", 64'(mem_rd), 64'd0);
    chk("s5_addr", 64'(sd_buff_addr), 64'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    xfer(21'd3, 32'd4096, 0, 256);
    chk("s5_w0", 64'(seen[0]), 64'h0300);
    chk("s5_w10", 64'(seen[10]), 64'h030A);

    // 6: sd_rd held and lba changed mid-transfer; the change applies only to the next request
    s0 = strobes;
    m0 = memrds;
    push_xfer(21'd0, 32'd1024);
    @(negedge clk);
    sd_lba   = 21'd0;
    img_size = 32'd1024;
    sd_rd    = 1'b1;
    wait_ack(1'b1, 50, "s6_ack_rise1");
    repeat (20) @(negedge clk);
    sd_lba = 21'd1;
    push_xfer(21'd1, 32'd1024);
    wait_ack(1'b0, 3000, "s6_ack_fall1");
    chk("s6_first_count", 64'(strobes - s0), 64'd256);
    wait_ack(1'b1, 50, "s6_ack_rise2");
    sd_rd = 1'b0;
    wait_ack(1'b0, 3000, "s6_ack_fall2");
    chk("s6_strobes", 64'(strobes - s0), 64'd512);
    chk("s6_mem_rd", 64'(memrds - m0), 64'd512);
    chk("s6_sb_drained", 64'(sb_q.size()), 64'd0);
    chk("s6_w255", 64'(seen[255]), 64'h01FF);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
